// File: rtl/hazard_detect_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit_if
// Bundles the ID-stage hazard inputs and the hazard unit's control outputs.
//   master : ID-stage side, drives the ID fields and consumes the controls
//   slave  : hazard unit side
// Signals:
//   rs1use, rs2use, hazard_optype, rs1_ID, rs2_ID, rd_ID, Branch_ID  (ID -> HDU)
//   pc_en, fd_en, fd_flush, de_flush, forward_a, forward_b, forward_ls,
//   stall_cnt, flush_cnt                                               (HDU -> ID)
// ---------------------------------------------------------------------------
interface hazard_detect_unit_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;

  logic             rs1use;
  logic             rs2use;
  logic [OP_W-1:0]  hazard_optype;
  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;
  logic [REG_W-1:0] rd_ID;
  logic             Branch_ID;

  logic             pc_en;
  logic             fd_en;
  logic             fd_flush;
  logic             de_flush;
  logic [FWD_W-1:0] forward_a;
  logic [FWD_W-1:0] forward_b;
  logic             forward_ls;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1use, rs2use, hazard_optype, rs1_ID, rs2_ID, rd_ID, Branch_ID,
    input  pc_en, fd_en, fd_flush, de_flush, forward_a, forward_b, forward_ls,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1use, rs2use, hazard_optype, rs1_ID, rs2_ID, rd_ID, Branch_ID,
    output pc_en, fd_en, fd_flush, de_flush, forward_a, forward_b, forward_ls,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Pipeline hazard detection: tracks the instructions in EX and MEM through two
// shadow slots, produces same-cycle forwarding selects, load-use stalls and
// branch flushes.
// Ports:
//   clk    pipeline clock (rising edge)
//   rst_n  asynchronous active-low reset
//   hdu    hazard_detect_unit_if.slave (ID fields in, pipeline controls out)
// Optional feature macro: HAZARD_STATS_EN builds saturating 16-bit stall and
// flush event counters; otherwise stall_cnt/flush_cnt are tied to zero.
// ---------------------------------------------------------------------------
module hazard_detect_unit (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_detect_unit_if.slave  hdu
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [OP_W-1:0] OP_NONE  = 2'b00;
  localparam logic [OP_W-1:0] OP_ALU   = 2'b01;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b10;
  localparam logic [OP_W-1:0] OP_STORE = 2'b11;

  localparam logic [FWD_W-1:0] FWD_RF      = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEM_LD  = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]  optype;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs2;
  } slot_t;

  localparam slot_t BUBBLE = '{optype: OP_NONE, rd: '0, rs2: '0};

  slot_t ex_q;
  slot_t mem_q;

  logic             ex_wr_c;
  logic             mem_wr_c;
  logic             ex_m1_c;
  logic             ex_m2_c;
  logic             mem_m1_c;
  logic             mem_m2_c;
  logic             stall_c;
  logic             pc_en_c;
  logic             fd_en_c;
  logic             fd_flush_c;
  logic             de_flush_c;
  logic [FWD_W-1:0] forward_a_c;
  logic [FWD_W-1:0] forward_b_c;
  logic             forward_ls_c;

  // Operand select for one source; a matching EX slot shadows MEM even when it
  // is a load (the load-use stall or store exception handles that case).
  function automatic logic [FWD_W-1:0] fwd_sel(input logic ex_m, input logic mem_m,
                                               input logic [OP_W-1:0] ex_op,
                                               input logic [OP_W-1:0] mem_op);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (ex_m) begin
      sel = (ex_op == OP_ALU) ? FWD_EX_ALU : FWD_RF;
    end else if (mem_m) begin
      sel = (mem_op == OP_ALU) ? FWD_MEM_ALU : FWD_MEM_LD;
    end
    return sel;
  endfunction

  // Register matching and stall/flush/forward decisions, all same-cycle.
  always_comb begin
    ex_wr_c      = 1'b0;
    mem_wr_c     = 1'b0;
    ex_m1_c      = 1'b0;
    ex_m2_c      = 1'b0;
    mem_m1_c     = 1'b0;
    mem_m2_c     = 1'b0;
    stall_c      = 1'b0;
    pc_en_c      = 1'b1;
    fd_en_c      = 1'b1;
    fd_flush_c   = 1'b0;
    de_flush_c   = 1'b0;
    forward_a_c  = FWD_RF;
    forward_b_c  = FWD_RF;
    forward_ls_c = 1'b0;

    // Only ALU writes and loads produce a value; x0 never forwards.
    ex_wr_c  = ((ex_q.optype == OP_ALU) || (ex_q.optype == OP_LOAD)) && (ex_q.rd != '0);
    mem_wr_c = ((mem_q.optype == OP_ALU) || (mem_q.optype == OP_LOAD)) && (mem_q.rd != '0);

    ex_m1_c  = hdu.rs1use && ex_wr_c  && (ex_q.rd  == hdu.rs1_ID);
    ex_m2_c  = hdu.rs2use && ex_wr_c  && (ex_q.rd  == hdu.rs2_ID);
    mem_m1_c = hdu.rs1use && mem_wr_c && (mem_q.rd == hdu.rs1_ID);
    mem_m2_c = hdu.rs2use && mem_wr_c && (mem_q.rd == hdu.rs2_ID);

    // A store only needs its data in MEM, so an rs2-only dependency on an EX
    // load is resolved later through forward_ls instead of stalling.
    stall_c = (ex_q.optype == OP_LOAD) &&
              (ex_m1_c || (ex_m2_c && (hdu.hazard_optype != OP_STORE)));

    forward_a_c = fwd_sel(ex_m1_c, mem_m1_c, ex_q.optype, mem_q.optype);
    forward_b_c = fwd_sel(ex_m2_c, mem_m2_c, ex_q.optype, mem_q.optype);

    forward_ls_c = (ex_q.optype == OP_STORE) && (mem_q.optype == OP_LOAD) &&
                   (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2);

    // Stall overrides the branch: the branch re-resolves next cycle.
    if (stall_c) begin
      pc_en_c    = 1'b0;
      fd_en_c    = 1'b0;
      de_flush_c = 1'b1;
      fd_flush_c = 1'b0;
    end else begin
      pc_en_c    = 1'b1;
      fd_en_c    = 1'b1;
      de_flush_c = 1'b0;
      fd_flush_c = hdu.Branch_ID;
    end
  end

  // Shadow slots: EX captures ID unless squashed, MEM follows EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
    end else begin
      mem_q <= ex_q;
      if (stall_c || de_flush_c) begin
        ex_q <= BUBBLE;
      end else begin
        ex_q <= '{optype: hdu.hazard_optype, rd: hdu.rd_ID, rs2: hdu.rs2_ID};
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (fd_flush_c && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hdu.stall_cnt = stall_cnt_q;
  assign hdu.flush_cnt = flush_cnt_q;
`else
  assign hdu.stall_cnt = '0;
  assign hdu.flush_cnt = '0;
`endif

  assign hdu.pc_en      = pc_en_c;
  assign hdu.fd_en      = fd_en_c;
  assign hdu.fd_flush   = fd_flush_c;
  assign hdu.de_flush   = de_flush_c;
  assign hdu.forward_a  = forward_a_c;
  assign hdu.forward_b  = forward_b_c;
  assign hdu.forward_ls = forward_ls_c;
endmodule

// File: tb/tb_hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_detect_unit
// Scenario tasks drive ID-stage instructions one per cycle, push the
// hand-derived control vector {pc_en,fd_en,fd_flush,de_flush,forward_a,
// forward_b,forward_ls} into a scoreboard queue and pop it against the DUT
// just after the falling edge. Counter expectations follow HAZARD_STATS_EN.
// ---------------------------------------------------------------------------
module tb_hazard_detect_unit;
  typedef struct packed {
    logic       r1u;
    logic       r2u;
    logic [1:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       br;
  } id_t;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [8:0] sb[$];

  hazard_detect_unit_if bus();

  hazard_detect_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_t mk(input logic r1u, input logic r2u, input logic [1:0] op,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic br);
    id_t s;
    s.r1u = r1u; s.r2u = r2u; s.op = op;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.br = br;
    return s;
  endfunction

  function automatic logic [8:0] ev(input logic pc, input logic fd, input logic ff,
                                    input logic df, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic fls);
    return {pc, fd, ff, df, fa, fb, fls};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_flush,
            bus.forward_a, bus.forward_b, bus.forward_ls};
  endfunction

  task automatic drive(input id_t s);
    bus.rs1use        = s.r1u;
    bus.rs2use        = s.r2u;
    bus.hazard_optype = s.op;
    bus.rs1_ID        = s.rs1;
    bus.rs2_ID        = s.rs2;
    bus.rd_ID         = s.rd;
    bus.Branch_ID     = s.br;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    reset_dut();
    #1;
    got = obs();
    checks++;
    if (got !== ev(1, 1, 0, 0, 2'b00, 2'b00, 0)) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got, ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_alu_forward();
    id_t        st[$];
    logic [8:0] ex[$];
    logic [8:0] got, want;
    reset_dut();
    st.push_back(mk(0, 0, 2'b01, 5'd0, 5'd0, 5'd5, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 0, 2'b01, 5'd5, 5'd0, 5'd6, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b01, 2'b00, 0));
    st.push_back(mk(1, 0, 2'b00, 5'd5, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b10, 2'b00, 0));
    st.push_back(mk(0, 1, 2'b00, 5'd0, 5'd6, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b10, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
      want = sb.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL alu_forward step %0d: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    id_t        st[$];
    logic [8:0] ex[$];
    logic [8:0] got, want;
    reset_dut();
    st.push_back(mk(1, 0, 2'b10, 5'd1, 5'd0, 5'd7, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(0, 1, 2'b01, 5'd0, 5'd7, 5'd8, 0)); ex.push_back(ev(0, 0, 0, 1, 2'b00, 2'b00, 0));
    st.push_back(mk(0, 1, 2'b01, 5'd0, 5'd7, 5'd8, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b11, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
      want = sb.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use step %0d: got %b want %b", i, got, want);
      end
    end
    checks++;
    if (bus.stall_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL load_use_stall_cnt: got %0d want %0d", bus.stall_cnt, STATS ? 16'd1 : 16'd0);
    end
  endtask

  task automatic test_store_forward();
    id_t        st[$];
    logic [8:0] ex[$];
    logic [8:0] got, want;
    reset_dut();
    st.push_back(mk(0, 0, 2'b10, 5'd0, 5'd0, 5'd7, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 1, 2'b11, 5'd2, 5'd7, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 1));
    st.push_back(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    // store whose address register depends on an EX load still stalls
    st.push_back(mk(0, 0, 2'b10, 5'd0, 5'd0, 5'd9, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 1, 2'b11, 5'd9, 5'd3, 5'd0, 0)); ex.push_back(ev(0, 0, 0, 1, 2'b00, 2'b00, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
      want = sb.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL store_forward step %0d: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_x0();
    id_t        st[$];
    logic [8:0] ex[$];
    logic [8:0] got, want;
    reset_dut();
    st.push_back(mk(0, 0, 2'b01, 5'd0, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 1, 2'b10, 5'd0, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 1, 2'b01, 5'd0, 5'd0, 5'd4, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
      want = sb.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL x0 step %0d: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_branch_stall();
    id_t        st[$];
    logic [8:0] ex[$];
    logic [8:0] got, want;
    reset_dut();
    st.push_back(mk(0, 0, 2'b10, 5'd0, 5'd0, 5'd7, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 0, 2'b00, 5'd7, 5'd0, 5'd0, 1)); ex.push_back(ev(0, 0, 0, 1, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 0, 2'b00, 5'd7, 5'd0, 5'd0, 1)); ex.push_back(ev(1, 1, 1, 0, 2'b11, 2'b00, 0));
    st.push_back(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
      want = sb.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch_stall step %0d: got %b want %b", i, got, want);
      end
    end
    checks++;
    if (bus.flush_cnt !== (STATS ? 16'd1 : 16'd0) || bus.stall_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL branch_counters: got stall=%0d flush=%0d want %0d/%0d",
               bus.stall_cnt, bus.flush_cnt, STATS ? 1 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    id_t        st[$];
    logic [8:0] ex[$];
    logic [8:0] got, want;
    reset_dut();
    st.push_back(mk(0, 0, 2'b10, 5'd0, 5'd0, 5'd3, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 0, 2'b10, 5'd3, 5'd0, 5'd4, 0)); ex.push_back(ev(0, 0, 0, 1, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 0, 2'b10, 5'd3, 5'd0, 5'd4, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b11, 2'b00, 0));
    st.push_back(mk(1, 1, 2'b01, 5'd4, 5'd3, 5'd5, 0)); ex.push_back(ev(0, 0, 0, 1, 2'b00, 2'b00, 0));
    st.push_back(mk(1, 1, 2'b01, 5'd4, 5'd3, 5'd5, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b11, 2'b00, 0));
    st.push_back(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0)); ex.push_back(ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
      want = sb.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, got, want);
      end
    end
    checks++;
    if (bus.stall_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL back_to_back_stall_cnt: got %0d want %0d", bus.stall_cnt, STATS ? 2 : 0);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [8:0] got;
    reset_dut();
    @(negedge clk); drive(mk(0, 0, 2'b10, 5'd0, 5'd0, 5'd7, 0));
    @(negedge clk); drive(mk(1, 0, 2'b01, 5'd7, 5'd0, 5'd8, 0));
    #1;
    got = obs();
    checks++;
    if (got !== ev(0, 0, 0, 1, 2'b00, 2'b00, 0)) begin
      errors++;
      $display("FAIL mid_stall_pre: got %b want %b", got, ev(0, 0, 0, 1, 2'b00, 2'b00, 0));
    end
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== ev(1, 1, 0, 0, 2'b00, 2'b00, 0) || bus.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_stall_async_reset: got %b cnt %0d want %b cnt 0",
               got, bus.stall_cnt, ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    end
    @(negedge clk); rst_n = 1'b1; #1;
    got = obs();
    checks++;
    if (got !== ev(1, 1, 0, 0, 2'b00, 2'b00, 0)) begin
      errors++;
      $display("FAIL mid_stall_after_release: got %b want %b", got, ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    end
  endtask

  task automatic test_saturation();
    logic [8:0] got;
    int unsigned pairs;
    pairs = STATS ? 32'd65540 : 32'd200;
    reset_dut();
    // self-dependent load: stalls every other cycle
    @(negedge clk); drive(mk(1, 0, 2'b10, 5'd7, 5'd0, 5'd7, 0));
    repeat (2 * pairs) @(negedge clk);
    #1;
    checks++;
    if (bus.stall_cnt !== (STATS ? 16'hFFFF : 16'd0) || bus.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL saturation: got stall=%h flush=%h want %h/0000",
               bus.stall_cnt, bus.flush_cnt, STATS ? 16'hFFFF : 16'h0);
    end
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 ||
        got !== ev(1, 1, 0, 0, 2'b00, 2'b00, 0)) begin
      errors++;
      $display("FAIL saturation_reset: got stall=%0d flush=%0d ctl=%b want 0/0/%b",
               bus.stall_cnt, bus.flush_cnt, got, ev(1, 1, 0, 0, 2'b00, 2'b00, 0));
    end
    @(negedge clk); rst_n = 1'b1;
    drive(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(mk(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0));
    test_reset();
    test_alu_forward();
    test_load_use();
    test_store_forward();
    test_x0();
    test_branch_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 rs1use, rs2use  input  1 each  ID-stage instruction reads rs1 / rs2.
REQ-004 hazard_optype  input  2  ID-stage class: 00 none (no rd write), 01 ALU write, 10 load, 11 store.
REQ-005 rs1_ID, rs2_ID, rd_ID  input  5 each  ID-stage register indices.
REQ-006 Branch_ID  input  1  ID-stage instruction redirects PC this cycle.
REQ-007 pc_en, fd_en  output  1 each  PC / IF-ID register write enables.
REQ-008 fd_flush, de_flush  output  1 each  squash IF-ID / ID-EX register contents.
REQ-009 forward_a, forward_b  output  2 each  ID operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-010 forward_ls  output  1  store data in EX taken from MEM load data.
REQ-011 stall_cnt, flush_cnt  output  16 each  event counters (see Configuration).

Function
REQ-012 Unit SHALL keep shadow slots EX and MEM, each holding {optype[1:0], rd[4:0], rs2[4:0]}.
REQ-013 Each rising edge: MEM <= EX; EX <= ID fields, or a bubble (optype 00) when stall or de_flush is active.
REQ-014 A slot SHALL match operand rsX only if rsXuse=1, slot optype is 01 or 10, slot rd != 0, and slot rd == rsX_ID.
REQ-015 Forward select per operand, with EX taking priority over MEM: EX match, optype 01 -> 01; MEM match, optype 01 -> 10; MEM match, optype 10 -> 11; otherwise 00.
REQ-016 Load-use stall SHALL assert when the EX slot has optype 10 and matches rs1, or matches rs2 while the ID optype is not 11.
REQ-017 Store exception: ID optype 11 with only an rs2 match on an EX load SHALL NOT stall; forward_b=00 for that cycle.
REQ-018 forward_ls SHALL be 1 iff the EX slot optype is 11, the MEM slot optype is 10, MEM rd != 0, and MEM rd == EX rs2.
REQ-019 During stall: pc_en=0, fd_en=0, de_flush=1, fd_flush=0.
REQ-020 With no stall: pc_en=1, fd_en=1, de_flush=0, fd_flush=Branch_ID.
REQ-021 Stall and Branch_ID in the same cycle: stall wins and no flush occurs; the branch re-evaluates next cycle with forwarded operands.
REQ-022 All outputs except the counters SHALL be combinational from the inputs and slot state, so they take effect in the same cycle.
REQ-023 Back-to-back loads feeding a dependent use SHALL stall exactly one cycle per EX-slot load dependency.

Reset
REQ-024 While rst_n=0: both slots hold bubbles and the counters are 0.
REQ-025 Post-reset outputs with idle inputs: pc_en=1, fd_en=1, flushes 0, forwards 00, forward_ls 0.
REQ-026 Reset asserted mid-stall SHALL clear the stall immediately; no stale slot state survives.

Configuration
REQ-027 With HAZARD_STATS_EN defined: stall_cnt increments on each stall cycle and flush_cnt on each fd_flush=1 cycle.
REQ-028 Both counters saturate at 16'hFFFF and never wrap.
REQ-029 Without HAZARD_STATS_EN: no counter registers are built, and stall_cnt and flush_cnt are tied to 0.

Verification
REQ-030 ALU write rd=5, then next ID uses rs1=5 -> forward_a=01, no stall; one cycle later (slot in MEM) -> forward_a=10.
REQ-031 Load rd=7, then next ID uses rs2=7 (ALU op) -> stall one cycle (pc_en=0, de_flush=1), then forward_b=11, stall_cnt=1.
REQ-032 Load rd=7, then store rs2=7 (rs1=2) -> no stall; the following cycle forward_ls=1.
REQ-033 Writes to rd=0 followed by a use of x0 -> forwards 00, no stall.
REQ-034 Load-use stall plus Branch_ID=1 in the same cycle -> fd_flush=0; next cycle Branch_ID=1 -> fd_flush=1, flush_cnt=1.
REQ-035 Drive 70000 stall cycles with HAZARD_STATS_EN defined -> stall_cnt=16'hFFFF; rst_n low mid-run -> counters 0 and slots bubbled asynchronously.
